// File: rtl/csr_regfile_pkg.sv
// rtl/csr_regfile_pkg.sv - shared CSR addresses, field layouts and privilege encodings
package csr_regfile_pkg;

    typedef enum logic [11:0] {
        CSR_MSTATUS    = 12'h300,
        CSR_MISA       = 12'h301,
        CSR_MIE        = 12'h304,
        CSR_MTVEC      = 12'h305,
        CSR_MCOUNTEREN = 12'h306,
        CSR_MSCRATCH   = 12'h340,
        CSR_MEPC       = 12'h341,
        CSR_MCAUSE     = 12'h342,
        CSR_MTVAL      = 12'h343,
        CSR_MIP        = 12'h344,
        CSR_TSELECT    = 12'h7A0,
        CSR_TDATA1     = 12'h7A1,
        CSR_MCYCLE     = 12'hB00,
        CSR_MINSTRET   = 12'hB02,
        CSR_CYCLE      = 12'hC00,
        CSR_INSTRET    = 12'hC02,
        CSR_MVENDORID  = 12'hF11,
        CSR_MARCHID    = 12'hF12,
        CSR_MIMPID     = 12'hF13,
        CSR_MHARTID    = 12'hF14,
        CSR_MCONFIGPTR = 12'hF15
    } rv_addr;

    // CSR_RD performs no write and never trips the read-only check
    typedef enum logic [1:0] {
        CSR_RD = 2'd0,
        CSR_RW = 2'd1,
        CSR_RS = 2'd2,
        CSR_RC = 2'd3
    } csr_op_e;

    localparam logic [1:0]  PRV_M         = 2'b11;
    localparam logic [1:0]  PRV_U         = 2'b00;
    localparam logic [1:0]  TVEC_DIRECT   = 2'd0;
    localparam logic [1:0]  TVEC_VECTORED = 2'd1;
    localparam logic [63:0] MIE_MASK      = 64'h888;

    typedef struct packed {
        logic [27:0] rsv63_36;
        logic [1:0]  sxl;
        logic [1:0]  uxl;
        logic [18:0] rsv31_13;
        logic [1:0]  mpp;
        logic [2:0]  rsv10_8;
        logic        mpie;
        logic [2:0]  rsv6_4;
        logic        mie;
        logic [2:0]  rsv2_0;
    } csr_status;

    typedef struct packed {
        logic [51:0] rsv63_12;
        logic        meip;
        logic [2:0]  rsv10_8;
        logic        mtip;
        logic [2:0]  rsv6_4;
        logic        msip;
        logic [2:0]  rsv2_0;
    } csr_ip;

    typedef struct packed {
        logic        irq;
        logic [62:0] code;
    } csr_cause;

    typedef struct packed {
        logic [61:0] base;
        logic [1:0]  mode;
    } csr_tvec;

    typedef struct packed {
        logic [1:0]  mxl;
        logic [35:0] rsv;
        logic [25:0] ext;
    } csr_misa;

endpackage

// File: rtl/csr_bus.sv
// rtl/csr_bus.sv - CSR request/response bus between execute/commit and the register file
interface csr_bus;
    logic        csr_en;
    logic [1:0]  op;
    logic [11:0] csr_addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        trap_ill;

    modport master (output csr_en, op, csr_addr, wdata, input rdata, trap_ill);
    modport slave  (input csr_en, op, csr_addr, wdata, output rdata, trap_ill);
endinterface

// File: rtl/csr_counter64.sv
// rtl/csr_counter64.sv - 64-bit counter with increment enable; a write beats the increment
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_en,
    input  logic        we,
    input  logic [63:0] wdata,
    output logic [63:0] count
);
    logic [63:0] cnt_q;
    logic [63:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (we) begin
            cnt_d = wdata;
        end else if (inc_en) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
endmodule

// File: rtl/csr_regfile.sv
// rtl/csr_regfile.sv - machine-mode CSR file with trap/mret handling; U-mode under CSR_USER_MODE_EN
module csr_regfile
    import csr_regfile_pkg::*;
#(
    parameter logic [63:0] HART_ID       = 64'd0,
    parameter logic [63:0] RESET_PC_TVEC = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    csr_bus.slave       bus,
    input  logic        trap_valid,
    input  logic [63:0] trap_cause,
    input  logic [63:0] trap_pc,
    input  logic [63:0] trap_tval,
    input  logic        mret_valid,
    input  logic        instret,
    input  logic        ext_mtip,
    input  logic        ext_msip,
    input  logic        ext_meip,
    output logic [63:0] redirect_pc,
    output logic        int_pending,
    output logic [1:0]  priv
);
`ifdef CSR_USER_MODE_EN
    localparam logic [1:0]  PRV_LEAST = PRV_U;
    localparam logic [25:0] MISA_EXT  = 26'h0101100;
`else
    localparam logic [25:0] MISA_EXT  = 26'h0001100;
`endif

    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [1:0]  mstatus_mpp_q, mstatus_mpp_d;
    logic [1:0]  priv_q, priv_d;
    logic [63:0] mie_q, mie_d;
    logic [63:0] mscratch_q, mscratch_d;
    logic [63:0] mepc_q, mepc_d;
    logic [63:0] mtval_q, mtval_d;
    csr_tvec     mtvec_q, mtvec_d;
    csr_cause    mcause_q, mcause_d;
`ifdef CSR_USER_MODE_EN
    logic        cnten_cy_q, cnten_cy_d;
    logic        cnten_ir_q, cnten_ir_d;
`endif

    csr_status   mstatus_rd;
    csr_misa     misa_rd;
    csr_ip       mip_rd;
    logic [63:0] mcycle, minstret;
    logic [63:0] rdata, new_val;
    logic        known, is_write, ctr_block, ill, wr_en, cnt_wr_ok;

    always_comb begin
        mstatus_rd      = '0;
        mstatus_rd.mie  = mstatus_mie_q;
        mstatus_rd.mpie = mstatus_mpie_q;
        mstatus_rd.mpp  = mstatus_mpp_q;
`ifdef CSR_USER_MODE_EN
        mstatus_rd.uxl  = 2'd2;
        mstatus_rd.sxl  = 2'd2;
`endif
        misa_rd         = '0;
        misa_rd.mxl     = 2'd2;
        misa_rd.ext     = MISA_EXT;
        mip_rd          = '0;
        mip_rd.mtip     = ext_mtip;
        mip_rd.msip     = ext_msip;
        mip_rd.meip     = ext_meip;
    end

    always_comb begin
        rdata = '0;
        known = 1'b1;
        case (bus.csr_addr)
            CSR_MSTATUS:    rdata = mstatus_rd;
            CSR_MISA:       rdata = misa_rd;
            CSR_MIE:        rdata = mie_q;
            CSR_MTVEC:      rdata = mtvec_q;
            CSR_MSCRATCH:   rdata = mscratch_q;
            CSR_MEPC:       rdata = mepc_q;
            CSR_MCAUSE:     rdata = mcause_q;
            CSR_MTVAL:      rdata = mtval_q;
            CSR_MIP:        rdata = mip_rd;
            CSR_MCYCLE, CSR_CYCLE:     rdata = mcycle;
            CSR_MINSTRET, CSR_INSTRET: rdata = minstret;
            CSR_MHARTID:    rdata = HART_ID;
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MCONFIGPTR,
            CSR_TSELECT, CSR_TDATA1: rdata = '0;
`ifdef CSR_USER_MODE_EN
            CSR_MCOUNTEREN: rdata = {61'd0, cnten_ir_q, 1'b0, cnten_cy_q};
`endif
            default:        known = 1'b0;
        endcase
    end

    always_comb begin
        is_write = (bus.op == CSR_RW) ||
                   (((bus.op == CSR_RS) || (bus.op == CSR_RC)) && (bus.wdata != 64'd0));
`ifdef CSR_USER_MODE_EN
        ctr_block = (priv_q == PRV_U) &&
                    (((bus.csr_addr == CSR_CYCLE) && !cnten_cy_q) ||
                     ((bus.csr_addr == CSR_INSTRET) && !cnten_ir_q));
`else
        ctr_block = 1'b0;
`endif
        ill = bus.csr_en && (!known || (is_write && (bus.csr_addr[11:10] == 2'b11)) ||
                             (bus.csr_addr[9:8] > priv_q) || ctr_block);
        wr_en     = bus.csr_en && is_write && !ill;
        cnt_wr_ok = wr_en && !trap_valid && !mret_valid;
        case (bus.op)
            CSR_RS:  new_val = rdata | bus.wdata;
            CSR_RC:  new_val = rdata & ~bus.wdata;
            default: new_val = bus.wdata;
        endcase
    end

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mstatus_mpp_d  = mstatus_mpp_q;
        priv_d         = priv_q;
        mie_d          = mie_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mtval_d        = mtval_q;
        mtvec_d        = mtvec_q;
        mcause_d       = mcause_q;
`ifdef CSR_USER_MODE_EN
        cnten_cy_d     = cnten_cy_q;
        cnten_ir_d     = cnten_ir_q;
`endif
        if (trap_valid) begin
            mepc_d         = trap_pc & ~64'h3;
            mcause_d       = csr_cause'(trap_cause);
            mtval_d        = trap_tval;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            mstatus_mpp_d  = priv_q;
            priv_d         = PRV_M;
        end else if (mret_valid) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
            priv_d         = mstatus_mpp_q;
`ifdef CSR_USER_MODE_EN
            mstatus_mpp_d  = PRV_LEAST;
`endif
        end else if (wr_en) begin
            case (bus.csr_addr)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = new_val[3];
                    mstatus_mpie_d = new_val[7];
                    mstatus_mpp_d  = (new_val[12:11] == PRV_M) ? PRV_M : PRV_U;
                end
                CSR_MIE:      mie_d      = new_val & MIE_MASK;
                CSR_MTVEC:    mtvec_d    = csr_tvec'({new_val[63:2],
                                  (new_val[1:0] == TVEC_VECTORED) ? TVEC_VECTORED : TVEC_DIRECT});
                CSR_MSCRATCH: mscratch_d = new_val;
                CSR_MEPC:     mepc_d     = new_val & ~64'h3;
                CSR_MCAUSE:   mcause_d   = csr_cause'(new_val);
                CSR_MTVAL:    mtval_d    = new_val;
`ifdef CSR_USER_MODE_EN
                CSR_MCOUNTEREN: begin
                    cnten_cy_d = new_val[0];
                    cnten_ir_d = new_val[2];
                end
`endif
                default: ;
            endcase
        end
`ifndef CSR_USER_MODE_EN
        // without U-mode the hart can never leave M, so mpp and priv stay pinned
        mstatus_mpp_d = PRV_M;
        priv_d        = PRV_M;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mstatus_mpp_q  <= PRV_M;
            priv_q         <= PRV_M;
            mie_q          <= '0;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mtval_q        <= '0;
            mtvec_q        <= csr_tvec'(RESET_PC_TVEC);
            mcause_q       <= '0;
`ifdef CSR_USER_MODE_EN
            cnten_cy_q     <= 1'b0;
            cnten_ir_q     <= 1'b0;
`endif
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mstatus_mpp_q  <= mstatus_mpp_d;
            priv_q         <= priv_d;
            mie_q          <= mie_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mtval_q        <= mtval_d;
            mtvec_q        <= mtvec_d;
            mcause_q       <= mcause_d;
`ifdef CSR_USER_MODE_EN
            cnten_cy_q     <= cnten_cy_d;
            cnten_ir_q     <= cnten_ir_d;
`endif
        end
    end

    csr_counter64 u_mcycle (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_en (1'b1),
        .we     (cnt_wr_ok && (bus.csr_addr == CSR_MCYCLE)),
        .wdata  (new_val),
        .count  (mcycle)
    );

    csr_counter64 u_minstret (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_en (instret),
        .we     (cnt_wr_ok && (bus.csr_addr == CSR_MINSTRET)),
        .wdata  (new_val),
        .count  (minstret)
    );

    always_comb begin
        redirect_pc = '0;
        if (trap_valid) begin
            redirect_pc = {mtvec_q.base, 2'b00};
            if ((mtvec_q.mode == TVEC_VECTORED) && trap_cause[63]) begin
                redirect_pc = {mtvec_q.base, 2'b00} + {trap_cause[61:0], 2'b00};
            end
        end else if (mret_valid) begin
            redirect_pc = mepc_q;
        end
    end

    assign int_pending  = mstatus_mie_q && ((mip_rd & mie_q) != 64'd0);
    assign priv         = priv_q;
    assign bus.rdata    = rdata;
    assign bus.trap_ill = ill;
endmodule

// File: tb/tb_csr_regfile.sv
// tb/tb_csr_regfile.sv - randomized self-checking bench for csr_regfile against a behavioural model
module tb_csr_regfile;
    localparam logic [63:0] HART     = 64'd5;
    localparam logic [63:0] TVEC_RST = 64'h8000_0000;
`ifdef CSR_USER_MODE_EN
    localparam bit UMODE = 1'b1;
`else
    localparam bit UMODE = 1'b0;
`endif
    localparam logic [11:0] A_MSTATUS = 12'h300, A_MISA = 12'h301, A_MIE = 12'h304, A_MTVEC = 12'h305;
    localparam logic [11:0] A_MCNTEN = 12'h306, A_MSCRATCH = 12'h340, A_MEPC = 12'h341;
    localparam logic [11:0] A_MCAUSE = 12'h342, A_MTVAL = 12'h343, A_MIP = 12'h344;
    localparam logic [11:0] A_TSEL = 12'h7A0, A_MCYCLE = 12'hB00, A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_CYCLE = 12'hC00, A_INSTRET = 12'hC02, A_MVENDOR = 12'hF11, A_MHART = 12'hF14;
    localparam logic [1:0]  OP_RD = 2'd0, OP_RW = 2'd1, OP_RS = 2'd2, OP_RC = 2'd3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    csr_bus bus ();
    logic        trap_valid, mret_valid, instret, ext_mtip, ext_msip, ext_meip;
    logic [63:0] trap_cause, trap_pc, trap_tval, redirect_pc;
    logic        int_pending;
    logic [1:0]  priv;

    csr_regfile #(.HART_ID(HART), .RESET_PC_TVEC(TVEC_RST)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
        .mret_valid(mret_valid), .instret(instret),
        .ext_mtip(ext_mtip), .ext_msip(ext_msip), .ext_meip(ext_meip),
        .redirect_pc(redirect_pc), .int_pending(int_pending), .priv(priv)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // architectural state as the programmer sees it
    bit          m_mie, m_mpie;
    logic [1:0]  m_mpp, m_priv;
    logic [63:0] m_mie_en, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_cnten;

    task automatic m_reset();
        m_mie = 0; m_mpie = 0; m_mpp = 2'b11; m_priv = 2'b11;
        m_mie_en = 0; m_mtvec = TVEC_RST; m_mscratch = 0; m_mepc = 0;
        m_mcause = 0; m_mtval = 0; m_cnten = 0;
    endtask

    function automatic logic [63:0] m_ip();
        return (64'(ext_meip) << 11) | (64'(ext_mtip) << 7) | (64'(ext_msip) << 3);
    endfunction

    function automatic bit m_known(input logic [11:0] a);
        case (a)
            A_MSTATUS, A_MISA, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE, A_MTVAL, A_MIP,
            12'h7A0, 12'h7A1, A_MCYCLE, A_MINSTRET, A_CYCLE, A_INSTRET,
            12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'hF15: return 1'b1;
            A_MCNTEN: return UMODE;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] m_read(input logic [11:0] a);
        case (a)
            A_MSTATUS: return (64'(m_mie) << 3) | (64'(m_mpie) << 7) | (64'(m_mpp) << 11) |
                              (UMODE ? ((64'd2 << 32) | (64'd2 << 34)) : 64'd0);
            A_MISA:    return (64'd2 << 62) | (64'd1 << 8) | (64'd1 << 12) | (UMODE ? (64'd1 << 20) : 64'd0);
            A_MIE:     return m_mie_en;
            A_MTVEC:   return m_mtvec;
            A_MCNTEN:  return UMODE ? m_cnten : 64'd0;
            A_MSCRATCH: return m_mscratch;
            A_MEPC:    return m_mepc;
            A_MCAUSE:  return m_mcause;
            A_MTVAL:   return m_mtval;
            A_MIP:     return m_ip();
            A_MHART:   return HART;
            default:   return 64'd0;
        endcase
    endfunction

    function automatic bit m_writes(input logic [1:0] op, input logic [63:0] wd);
        return (op == OP_RW) || ((op == OP_RS || op == OP_RC) && wd != 0);
    endfunction

    function automatic bit m_ill(input logic [11:0] a, input logic [1:0] op, input logic [63:0] wd);
        bit ctr;
        ctr = UMODE && m_priv == 2'b00 &&
              ((a == A_CYCLE && m_cnten[0] == 1'b0) || (a == A_INSTRET && m_cnten[2] == 1'b0));
        return !m_known(a) || (m_writes(op, wd) && a[11:10] == 2'b11) || (a[9:8] > m_priv) || ctr;
    endfunction

    task automatic m_write(input logic [11:0] a, input logic [1:0] op, input logic [63:0] wd);
        logic [63:0] nv;
        nv = (op == OP_RW) ? wd : (op == OP_RS) ? (m_read(a) | wd) : (m_read(a) & ~wd);
        case (a)
            A_MSTATUS: begin
                m_mie = nv[3]; m_mpie = nv[7];
                if (UMODE) m_mpp = (nv[12:11] == 2'b11) ? 2'b11 : 2'b00;
            end
            A_MIE:      m_mie_en = nv & 64'h888;
            A_MTVEC:    m_mtvec = (nv & ~64'h3) | ((nv[1:0] == 2'd1) ? 64'd1 : 64'd0);
            A_MCNTEN:   m_cnten = nv & 64'h5;
            A_MSCRATCH: m_mscratch = nv;
            A_MEPC:     m_mepc = nv & ~64'h3;
            A_MCAUSE:   m_mcause = nv;
            A_MTVAL:    m_mtval = nv;
            default: ;
        endcase
    endtask

    function automatic logic [63:0] m_trap_target(input logic [63:0] cause);
        return (m_mtvec & ~64'h3) + ((m_mtvec[1:0] == 2'd1 && cause[63]) ? 4 * cause : 64'd0);
    endfunction

    task automatic step(input bit en, input logic [1:0] op, input logic [11:0] a, input logic [63:0] wd,
                        input bit tv, input bit mv, input logic [63:0] cause, input logic [63:0] pc,
                        input string tag);
        bit ill;
        logic [63:0] exp_redir;
        bus.csr_en = en; bus.op = op; bus.csr_addr = a; bus.wdata = wd;
        trap_valid = tv; mret_valid = mv; trap_cause = cause; trap_pc = pc; trap_tval = ~pc;
        ill = en && m_ill(a, op, wd);
        exp_redir = tv ? m_trap_target(cause) : (mv ? m_mepc : 64'd0);
        @(negedge clk);
        if (en && !(a == A_MCYCLE || a == A_MINSTRET || a == A_CYCLE || a == A_INSTRET))
            check({tag, ".rdata"}, bus.rdata, m_read(a));
        check({tag, ".ill"}, 64'(bus.trap_ill), 64'(ill));
        check({tag, ".redir"}, redirect_pc, exp_redir);
        check({tag, ".intp"}, 64'(int_pending), 64'(m_mie && ((m_ip() & m_mie_en) != 0)));
        check({tag, ".priv"}, 64'(priv), 64'(m_priv));
        @(posedge clk);
        #1;
        if (tv) begin
            m_mepc = pc & ~64'h3; m_mcause = cause; m_mtval = ~pc;
            m_mpie = m_mie; m_mie = 0; m_mpp = m_priv; m_priv = 2'b11;
        end else if (mv) begin
            m_mie = m_mpie; m_mpie = 1; m_priv = m_mpp; m_mpp = UMODE ? 2'b00 : 2'b11;
        end else if (en && !ill && m_writes(op, wd)) begin
            m_write(a, op, wd);
        end
        bus.csr_en = 0; trap_valid = 0; mret_valid = 0;
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [63:0] wd, input string tag);
        step(1, op, a, wd, 0, 0, 64'd0, 64'd0, tag);
    endtask

    task automatic peek(input logic [11:0] a, input logic [63:0] exp, input string tag);
        bus.csr_en = 1; bus.op = OP_RD; bus.csr_addr = a; bus.wdata = 0;
        @(negedge clk);
        check(tag, bus.rdata, exp);
        @(posedge clk);
        #1;
        bus.csr_en = 0;
    endtask

    logic [11:0] addrs [13] = '{A_MSTATUS, A_MISA, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE,
                                A_MTVAL, A_MIP, A_MVENDOR, A_MHART, A_TSEL, A_MCNTEN};

    initial begin
        rst_n = 0;
        bus.csr_en = 0; bus.op = 0; bus.csr_addr = 0; bus.wdata = 0;
        trap_valid = 0; mret_valid = 0; instret = 0; trap_cause = 0; trap_pc = 0; trap_tval = 0;
        ext_mtip = 0; ext_msip = 0; ext_meip = 0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.rdata", bus.rdata, 64'd0);
        check("rst.ill", 64'(bus.trap_ill), 64'd0);
        check("rst.redir", redirect_pc, 64'd0);
        check("rst.intp", 64'(int_pending), 64'd0);
        check("rst.priv", 64'(priv), 64'd3);
        @(posedge clk);
        #1;
        rst_n = 1;

        peek(A_MTVEC, TVEC_RST, "rst.mtvec");
        peek(A_MHART, HART, "rst.mhartid");
        check("rst.mpp", 64'(bus.rdata[12:11]), 64'd0);
        csr(OP_RD, A_MSTATUS, 0, "rst.mstatus");

        csr(OP_RW, A_MSCRATCH, 64'hDEAD_BEEF, "scr.rw");
        peek(A_MSCRATCH, 64'hDEAD_BEEF, "scr.after_rw");
        csr(OP_RS, A_MSCRATCH, 64'hF0, "scr.rs");
        peek(A_MSCRATCH, 64'hDEAD_BEFF, "scr.after_rs");
        csr(OP_RC, A_MSCRATCH, 64'h0F, "scr.rc");
        peek(A_MSCRATCH, 64'hDEAD_BEF0, "scr.after_rc");

        csr(OP_RW, A_MVENDOR, 64'h5, "ill.mvendorid_wr");
        csr(OP_RW, 12'h7C0, 64'h1, "ill.unknown");
        csr(OP_RW, A_CYCLE, 64'h1, "ill.cycle_wr");
        peek(A_MSCRATCH, 64'hDEAD_BEF0, "ill.no_change");
        csr(OP_RS, A_MVENDOR, 64'h0, "ill.rs_zero");
        csr(OP_RW, A_TSEL, 64'hFF, "tsel.wr");
        csr(OP_RD, A_TSEL, 0, "tsel.rd");

        csr(OP_RW, A_MTVEC, 64'h1001, "irq.mtvec");
        csr(OP_RW, A_MIE, 64'h80, "irq.mie");
        csr(OP_RS, A_MSTATUS, 64'h8, "irq.mstatus");
        ext_mtip = 1;
        #1;
        check("irq.pending", 64'(int_pending), 64'd1);
        step(0, 0, 0, 0, 1, 0, 64'h8000_0000_0000_0007, 64'h4000, "irq.trap");
        check("irq.redir_const", m_trap_target(64'h8000_0000_0000_0007), 64'h101C);
        peek(A_MSTATUS, 64'h1880 | (UMODE ? ((64'd2 << 32) | (64'd2 << 34)) : 64'd0), "irq.mstatus_after");
        step(0, 0, 0, 0, 0, 1, 0, 0, "irq.mret");
        csr(OP_RD, A_MSTATUS, 0, "irq.mstatus_mret");
        ext_mtip = 0;

        step(1, OP_RW, A_MEPC, 64'h1234, 1, 0, 64'd2, 64'h5000, "pri.trap_vs_wr");
        peek(A_MEPC, 64'h5000, "pri.mepc");
        step(1, OP_RW, A_MSCRATCH, 64'h77, 0, 1, 0, 0, "pri.mret_vs_wr");
        peek(A_MSCRATCH, 64'hDEAD_BEF0, "pri.scr_kept");

        csr(OP_RW, A_MCYCLE, 64'hFFFF_FFFF_FFFF_FFFF, "cnt.mcycle_wr");
        bus.csr_en = 1; bus.op = OP_RD; bus.csr_addr = A_MCYCLE;
        @(negedge clk);
        check("cnt.mcycle_max", bus.rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        check("cnt.mcycle_wrap", bus.rdata, 64'd0);
        @(posedge clk);
        #1;
        bus.op = OP_RW; bus.csr_addr = A_MINSTRET; bus.wdata = 64'd10; instret = 1;
        @(posedge clk);
        #1;
        bus.csr_en = 0;
        repeat (3) @(posedge clk);
        #1;
        instret = 0; bus.csr_en = 1; bus.op = OP_RD;
        @(negedge clk);
        check("cnt.minstret", bus.rdata, 64'd13);
        bus.csr_addr = A_INSTRET;
        #1;
        check("cnt.instret_alias", bus.rdata, 64'd13);
        @(posedge clk);
        #1;
        bus.csr_en = 0;

`ifdef CSR_USER_MODE_EN
        csr(OP_RC, A_MSTATUS, 64'h1800, "u.mpp0");
        step(0, 0, 0, 0, 0, 1, 0, 0, "u.mret");
        check("u.priv", 64'(priv), 64'd0);
        csr(OP_RD, A_MSTATUS, 0, "u.mstatus_ill");
        csr(OP_RD, A_CYCLE, 0, "u.cycle_ill");
        step(0, 0, 0, 0, 1, 0, 64'd8, 64'h6000, "u.trap");
        csr(OP_RW, A_MCNTEN, 64'h1, "u.cnten");
        csr(OP_RC, A_MSTATUS, 64'h1800, "u.mpp0b");
        step(0, 0, 0, 0, 0, 1, 0, 0, "u.mret2");
        csr(OP_RD, A_CYCLE, 0, "u.cycle_ok");
        step(0, 0, 0, 0, 1, 0, 64'd8, 64'h6000, "u.trap2");
`endif

        for (int i = 0; i < 300; i++) begin
            int ev;
            logic [11:0] a;
            logic [1:0] op;
            logic [63:0] wd, cause, pc;
            ext_mtip = 1'($urandom_range(0, 1));
            ext_msip = 1'($urandom_range(0, 1));
            ext_meip = 1'($urandom_range(0, 1));
            ev = $urandom_range(0, 9);
            a = addrs[$urandom_range(0, 12)];
            op = 2'($urandom_range(0, 3));
            wd = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) wd = 64'd0;
            cause = {1'($urandom_range(0, 1)), 59'd0, 4'($urandom_range(0, 15))};
            pc = {$urandom, $urandom};
            case (ev)
                0: step(0, op, a, wd, 1, 0, cause, pc, "rnd.trap");
                1: step(0, op, a, wd, 0, 1, cause, pc, "rnd.mret");
                2: step(1, op, a, wd, 1, 0, cause, pc, "rnd.trap_wr");
                default: step(1, op, a, wd, 0, 0, cause, pc, "rnd.csr");
            endcase
        end

        #3;
        rst_n = 0;
        m_reset();
        #1;
        bus.csr_en = 1; bus.op = OP_RD; bus.csr_addr = A_MTVEC;
        #1;
        check("arst.mtvec", bus.rdata, TVEC_RST);
        check("arst.priv", 64'(priv), 64'(m_priv));
        bus.csr_addr = A_MSCRATCH;
        #1;
        check("arst.mscratch", bus.rdata, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
